// File: rtl/loader_pkg.sv
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared types and helpers for the UART program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_ACK  = 3'd2,
        ST_NAK  = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_ACK = 8'hAA;
    localparam logic [7:0] DEFAULT_NAK = 8'hEE;

    // Replace byte lane 'lane' of a 32-bit word (lane 0 = bits [7:0]).
    function automatic logic [31:0] set_lane(input logic [31:0] w,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_word_asm.sv
// ============================================================================
// Module   : loader_word_asm
// Brief    : Assembles four little-endian bytes into one 32-bit word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module loader_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [31:0] acc;

    // The fourth byte is merged combinationally so the word can be stored
    // on the same edge that accepts it.
    assign word_valid = byte_valid && (byte_idx == 2'd3);
    assign word       = set_lane(acc, 2'd3, byte_in);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_idx <= 2'd0;
            acc      <= '0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            acc      <= '0;
        end else if (byte_valid) begin
            acc      <= set_lane(acc, byte_idx, byte_in);
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_program_loader.sv
// ============================================================================
// Module   : uart_program_loader
// Brief    : Receives an instruction image over UART, answers ACK/NAK, then
//            releases the core from reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_program_loader
    import loader_pkg::*;
#(
    parameter int         WORDS       = 32,
    parameter logic [7:0] ACK_BYTE    = DEFAULT_ACK,
    parameter logic [7:0] NAK_BYTE    = DEFAULT_NAK,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           rdata,
    input  logic                 rx_ready,
    input  logic                 ferr,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [32*WORDS-1:0]  i_memory,
    output logic                 core_rstn,
    output logic                 loaded,
    output logic                 error
);

    localparam int WIDX_W = $clog2(WORDS + 1);
    localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t            state, next_state;
    logic [WIDX_W-1:0] n_words;
    logic [WIDX_W-1:0] word_idx;
    logic              byte_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic              tmo_hit;
    logic              load_count;
    logic              enter_ack;
    logic              enter_nak;
    logic              send;

    assign byte_valid = (state == ST_RECV) && rx_ready && !ferr;
    assign core_rstn  = (state == ST_RUN);
    assign loaded     = (state == ST_RUN);

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (state != ST_RECV),
        .byte_valid (byte_valid),
        .byte_in    (rdata),
        .word_valid (word_valid),
        .word       (word)
    );

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
            logic [TMO_W-1:0] tmo_cnt;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)
                    tmo_cnt <= '0;
                else if (state == ST_RECV && !rx_ready && !tmo_hit)
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                else
                    tmo_cnt <= '0;
            end

            // A byte arriving on the terminal cycle takes priority.
            assign tmo_hit = (state == ST_RECV) && !rx_ready && (tmo_cnt == TMO_LAST);
        end else begin : g_no_timeout
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_count = 1'b0;
        enter_ack  = 1'b0;
        enter_nak  = 1'b0;
        send       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_ready) begin
                    if (!ferr && rdata != 8'd0 && int'(rdata) <= WORDS) begin
                        next_state = ST_RECV;
                        load_count = 1'b1;
                    end else begin
                        next_state = ST_NAK;
                        enter_nak  = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (rx_ready && ferr) begin
                    next_state = ST_NAK;
                    enter_nak  = 1'b1;
                end else if (word_valid && (word_idx + WIDX_W'(1)) == n_words) begin
                    next_state = ST_ACK;
                    enter_ack  = 1'b1;
                end else if (tmo_hit) begin
                    next_state = ST_NAK;
                    enter_nak  = 1'b1;
                end
            end
            ST_ACK, ST_NAK: begin
                // Leave on the cycle after the strobe so it stays one cycle wide.
                if (tx_start)
                    next_state = (state == ST_ACK) ? ST_RUN : ST_IDLE;
                else if (!tx_busy)
                    send = 1'b1;
            end
            ST_RUN: begin
                next_state = ST_RUN;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_memory <= '0;
            tx_data  <= 8'd0;
            tx_start <= 1'b0;
            error    <= 1'b0;
            n_words  <= '0;
            word_idx <= '0;
        end else begin
            tx_start <= send;
            if (load_count) begin
                n_words  <= WIDX_W'(rdata);
                word_idx <= '0;
                i_memory <= '0;
                error    <= 1'b0;
            end
            if (word_valid) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (word_idx == WIDX_W'(k))
                        i_memory[k*32 +: 32] <= word;
                end
                word_idx <= word_idx + WIDX_W'(1);
            end
            if (enter_ack)
                tx_data <= ACK_BYTE;
            if (enter_nak) begin
                tx_data <= NAK_BYTE;
                error   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_program_loader.sv
// ============================================================================
// Module   : tb_uart_program_loader
// Brief    : Directed scoreboard bench for uart_program_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_program_loader;

    localparam int WORDS = 32;
    localparam int TMO   = 100;

    logic                clk      = 1'b0;
    logic                rstn     = 1'b0;
    logic [7:0]          rdata    = 8'd0;
    logic                rx_ready = 1'b0;
    logic                ferr     = 1'b0;
    logic                tx_busy  = 1'b0;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic [32*WORDS-1:0] i_memory;
    logic                core_rstn;
    logic                loaded;
    logic                error;

    int                  tests = 0;
    int                  fails = 0;
    logic [7:0]          exp_q[$];
    logic [32*WORDS-1:0] exp_mem;
    logic [31:0]         img [WORDS];

    uart_program_loader #(
        .WORDS       (WORDS),
        .ACK_BYTE    (8'hAA),
        .NAK_BYTE    (8'hEE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rdata     (rdata),
        .rx_ready  (rx_ready),
        .ferr      (ferr),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .i_memory  (i_memory),
        .core_rstn (core_rstn),
        .loaded    (loaded),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chkmem(input string tag, input logic [32*WORDS-1:0] got,
                          input logic [32*WORDS-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(negedge clk);
        rdata    = b;
        ferr     = fe;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        ferr     = 1'b0;
    endtask

    task automatic set_image(input int n);
        exp_mem = '0;
        for (int k = 0; k < n; k++) begin
            img[k] = $urandom;
            exp_mem[k*32 +: 32] = img[k];
        end
    endtask

    task automatic send_image(input int n);
        send_byte(8'(n), 1'b0);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 4; j++)
                send_byte(img[k][8*j +: 8], 1'b0);
    endtask

    // Waits for the tx strobe, pops the expected byte and checks the pulse.
    task automatic wait_tx(input string tag, output int cyc);
        logic [7:0] e;
        logic       seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (tx_start) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
        chk1({tag, "_tx_seen"}, seen, 1'b1);
        if (seen) begin
            chk1({tag, "_q_nonempty"}, exp_q.size() > 0, 1'b1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            chk8({tag, "_tx_byte"}, tx_data, e);
            chk1({tag, "_rstn_at_pulse"}, core_rstn, 1'b0);
            @(negedge clk);
            chk1({tag, "_pulse_width"}, tx_start, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        int c;
        int pulses;

        // Reset state
        repeat (3) @(negedge clk);
        chk1("rst_tx_start", tx_start, 1'b0);
        chk1("rst_core_rstn", core_rstn, 1'b0);
        chk1("rst_loaded", loaded, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk8("rst_tx_data", tx_data, 8'h00);
        chkmem("rst_mem", i_memory, '0);
        rstn = 1'b1;

        // 1) Two-word image
        img[0]  = 32'h00100093;
        img[1]  = 32'h00100113;
        exp_mem = '0;
        exp_mem[31:0]  = 32'h00100093;
        exp_mem[63:32] = 32'h00100113;
        exp_q.push_back(8'hAA);
        send_image(2);
        wait_tx("t1", c);
        chkmem("t1_mem", i_memory, exp_mem);
        chk1("t1_core_rstn", core_rstn, 1'b1);
        chk1("t1_loaded", loaded, 1'b1);
        chk1("t1_error", error, 1'b0);

        // 2) Bad count bytes, then a good load
        do_reset();
        exp_q.push_back(8'hEE);
        send_byte(8'h00, 1'b0);
        wait_tx("t2a", c);
        chk1("t2a_error", error, 1'b1);
        chk1("t2a_core_rstn", core_rstn, 1'b0);
        exp_q.push_back(8'hEE);
        send_byte(8'h21, 1'b0);
        wait_tx("t2b", c);
        chk1("t2b_error", error, 1'b1);
        chk1("t2b_core_rstn", core_rstn, 1'b0);
        set_image(1);
        exp_q.push_back(8'hAA);
        send_image(1);
        wait_tx("t2c", c);
        chk1("t2c_error", error, 1'b0);
        chk1("t2c_core_rstn", core_rstn, 1'b1);
        chkmem("t2c_mem", i_memory, exp_mem);

        // 3) Timeout after three data bytes
        do_reset();
        set_image(1);
        exp_mem = '0;
        exp_q.push_back(8'hEE);
        send_byte(8'd1, 1'b0);
        for (int j = 0; j < 3; j++)
            send_byte(img[0][8*j +: 8], 1'b0);
        wait_tx("t3", c);
        chk1("t3_delay_window", (c >= TMO) && (c <= TMO + 2), 1'b1);
        chk1("t3_error", error, 1'b1);
        chk1("t3_core_rstn", core_rstn, 1'b0);
        chk1("t3_loaded", loaded, 1'b0);
        chkmem("t3_mem", i_memory, exp_mem);

        // 4) Framing error on second data byte while uart_tx is busy
        do_reset();
        tx_busy = 1'b1;
        set_image(2);
        exp_q.push_back(8'hEE);
        send_byte(8'd2, 1'b0);
        send_byte(img[0][7:0], 1'b0);
        send_byte(img[0][15:8], 1'b1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) pulses++;
        end
        chk1("t4_held_while_busy", pulses == 0, 1'b1);
        tx_busy = 1'b0;
        wait_tx("t4", c);
        chk1("t4_prompt_after_busy", c <= 3, 1'b1);
        chk8("t4_tx_data_held", tx_data, 8'hEE);
        chk1("t4_error", error, 1'b1);
        chk1("t4_core_rstn", core_rstn, 1'b0);

        // 5) Full 32-word image, then bytes ignored in RUN
        do_reset();
        set_image(WORDS);
        exp_q.push_back(8'hAA);
        send_image(WORDS);
        wait_tx("t5", c);
        chkmem("t5_mem", i_memory, exp_mem);
        chk32("t5_word31", i_memory[1023:992], img[31]);
        chk1("t5_core_rstn", core_rstn, 1'b1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte((i == 0) ? 8'd1 : 8'($urandom), 1'b0);
            if (tx_start) pulses++;
        end
        chkmem("t5_mem_after_extra", i_memory, exp_mem);
        chk1("t5_no_tx_in_run", pulses == 0, 1'b1);
        chk1("t5_loaded_kept", loaded, 1'b1);

        // 6) Reset asserted mid-RECV, then reload
        do_reset();
        set_image(4);
        send_byte(8'd4, 1'b0);
        for (int j = 0; j < 4; j++)
            send_byte(img[0][8*j +: 8], 1'b0);
        send_byte(img[1][7:0], 1'b0);
        chk32("t6_word0_partial", i_memory[31:0], img[0]);
        #2;
        rstn = 1'b0;
        #1;
        chkmem("t6_rst_mem", i_memory, '0);
        chk1("t6_rst_core_rstn", core_rstn, 1'b0);
        chk1("t6_rst_loaded", loaded, 1'b0);
        chk1("t6_rst_error", error, 1'b0);
        chk1("t6_rst_tx_start", tx_start, 1'b0);
        chk8("t6_rst_tx_data", tx_data, 8'h00);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        set_image(1);
        exp_q.push_back(8'hAA);
        send_image(1);
        wait_tx("t6", c);
        chkmem("t6_reload_mem", i_memory, exp_mem);
        chk1("t6_reload_core_rstn", core_rstn, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
